// File: rtl/lcd_rx_monitor.sv
// lcd_rx_monitor: receive side of the 4-bit character-LCD write bus.
// It synchronizes the bus, qualifies E strobes and tracks the 8-bit/4-bit
// power-on handshake. Nibbles are assembled into bytes, and the command
// subset is decoded. An 8-slot DDRAM image is kept as 5-bit character codes.
//
// Handshake: the bus has no valid/ready pair. A byte or nibble is "valid"
// on a qualified E falling edge (E high >= MIN_E_HIGH synced cycles, R/W'=0).
// The monitor is always ready, and the sender must space strobes >= 4 clk apart.
module lcd_rx_monitor #(
    parameter int MIN_E_HIGH  = 4,
    parameter int NIB_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  lcd_data,
    input  logic [2:0]  lcd_ctrl,
    output logic [39:0] frame,
    output logic        frame_valid,
    output logic        display_on,
    output logic        four_bit,
    output logic        err,
    output logic        o_dbg_phase
);

    localparam int EW = $clog2(MIN_E_HIGH + 1);
    localparam int TW = $clog2(NIB_TIMEOUT + 1);

    typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

    // synchronizer, edge detect and hold registers
    logic [3:0]    r_data_s1, r_data_s2;
    logic [2:0]    r_ctrl_s1, r_ctrl_s2;
    logic          r_e_prev;
    logic [EW-1:0] r_e_cnt;
    logic [3:0]    r_hold_data;
    logic          r_hold_dc;
    logic          r_hold_rw;

    // protocol state
    phase_t        r_phase, w_phase_nx;
    logic          r_four_bit, w_four_bit_nx;
    logic [3:0]    r_hi_nib, w_hi_nib_nx;
    logic          r_hi_dc, w_hi_dc_nx;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nx;
    logic [6:0]    r_addr, w_addr_nx;
    logic          r_inc, w_inc_nx;
    logic          r_disp, w_disp_nx;
    logic [39:0]   r_frame, w_frame_nx;
    logic          r_fv, w_fv_nx;
    logic          r_err, w_err_nx;

    logic          w_strobe;
    logic          w_to_expire;
    logic          w_commit;
    logic [7:0]    w_byte;
    logic          w_byte_dc;
    logic [5:0]    w_map;

    // Map an ASCII byte back to its 5-bit code; bit 5 flags an unmappable value.
    function automatic logic [5:0] f_map(input logic [7:0] c);
        logic [5:0] m;
        m = {1'b1, 5'd31};
        if (c >= 8'h30 && c <= 8'h39) begin
            m = {2'b00, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            m = {1'b0, 5'({1'b0, c[3:0]} + 5'd9)};
        end else begin
            case (c)
                8'h2E:        m = {1'b0, 5'd16};
                8'h3A:        m = {1'b0, 5'd17};
                8'h2B:        m = {1'b0, 5'd18};
                8'h2D:        m = {1'b0, 5'd19};
                8'h2A:        m = {1'b0, 5'd20};
                8'h2F:        m = {1'b0, 5'd21};
                8'h28:        m = {1'b0, 5'd22};
                8'h29:        m = {1'b0, 5'd23};
                8'h3C:        m = {1'b0, 5'd24};
                8'h3E:        m = {1'b0, 5'd25};
                8'h6D:        m = {1'b0, 5'd26};
                8'h53:        m = {1'b0, 5'd27};
                8'hE4:        m = {1'b0, 5'd28};
                8'hF4:        m = {1'b0, 5'd29};
                8'h3D:        m = {1'b0, 5'd30};
                8'hFE, 8'h20: m = {1'b0, 5'd31};
                default:      m = {1'b1, 5'd31};
            endcase
        end
        return m;
    endfunction

    // Two-stage sync of the bus, E-high width counter and hold registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_s1   <= '0;
            r_data_s2   <= '0;
            r_ctrl_s1   <= '0;
            r_ctrl_s2   <= '0;
            r_e_prev    <= 1'b0;
            r_e_cnt     <= '0;
            r_hold_data <= '0;
            r_hold_dc   <= 1'b0;
            r_hold_rw   <= 1'b0;
        end else begin
            r_data_s1 <= lcd_data;
            r_data_s2 <= r_data_s1;
            r_ctrl_s1 <= lcd_ctrl;
            r_ctrl_s2 <= r_ctrl_s1;
            r_e_prev  <= r_ctrl_s2[2];
            if (r_ctrl_s2[2]) begin
                if (r_e_cnt != EW'(MIN_E_HIGH)) begin
                    r_e_cnt <= r_e_cnt + EW'(1);
                end
                r_hold_data <= r_data_s2;
                r_hold_dc   <= r_ctrl_s2[1];
                r_hold_rw   <= r_ctrl_s2[0];
            end else begin
                r_e_cnt <= '0;
            end
        end
    end

    assign w_strobe    = !r_ctrl_s2[2] && r_e_prev &&
                         (r_e_cnt >= EW'(MIN_E_HIGH)) && !r_hold_rw;
    assign w_to_expire = (r_phase == PH_LOW) && (r_to_cnt == TW'(NIB_TIMEOUT - 1));

    // In 4-bit mode the byte pairs the stored high nibble with the held low one.
    assign w_byte    = r_four_bit ? {r_hi_nib, r_hold_data} : {r_hold_data, 4'h0};
    assign w_byte_dc = r_four_bit ? r_hi_dc : r_hold_dc;
    assign w_map     = f_map(w_byte);

    // Phase FSM, nibble assembly, command decode and DDRAM write.
    always_comb begin
        w_phase_nx    = r_phase;
        w_four_bit_nx = r_four_bit;
        w_hi_nib_nx   = r_hi_nib;
        w_hi_dc_nx    = r_hi_dc;
        w_to_cnt_nx   = (r_phase == PH_LOW) ? r_to_cnt + TW'(1) : r_to_cnt;
        w_addr_nx     = r_addr;
        w_inc_nx      = r_inc;
        w_disp_nx     = r_disp;
        w_frame_nx    = r_frame;
        w_fv_nx       = 1'b0;
        w_err_nx      = 1'b0;
        w_commit      = 1'b0;

        if (!r_four_bit) begin
            // 8-bit mode: every strobe is a whole command; data is dropped
            if (w_strobe && !r_hold_dc) begin
                w_commit = 1'b1;
            end
        end else if (r_phase == PH_HIGH || w_to_expire) begin
            if (w_to_expire) begin
                w_phase_nx = PH_HIGH;
                w_err_nx   = 1'b1;
            end
            // a strobe coinciding with expiry starts a fresh byte
            if (w_strobe) begin
                w_hi_nib_nx = r_hold_data;
                w_hi_dc_nx  = r_hold_dc;
                w_phase_nx  = PH_LOW;
                w_to_cnt_nx = '0;
            end
        end else if (w_strobe) begin
            w_commit   = 1'b1;
            w_phase_nx = PH_HIGH;
        end

        if (w_commit && !w_byte_dc) begin
            casez (w_byte)
                8'b1???????: w_addr_nx = w_byte[6:0];
                8'b01??????: ;
                8'b001?????: begin
                    if (w_byte[4]) begin
                        w_four_bit_nx = 1'b0;
                        w_phase_nx    = PH_HIGH;
                    end else if (!r_four_bit) begin
                        w_four_bit_nx = 1'b1;
                        w_phase_nx    = PH_HIGH;
                    end
                end
                8'b0001????: ;
                8'b00001???: w_disp_nx = w_byte[2];
                8'b000001??: w_inc_nx = w_byte[1];
                8'b0000001?: w_addr_nx = 7'd0;
                8'b00000001: begin
                    w_frame_nx = '1;
                    w_addr_nx  = 7'd0;
                    w_inc_nx   = 1'b1;
                end
                default: ;
            endcase
        end else if (w_commit && w_byte_dc) begin
            if (r_addr[6:3] == 4'd0) begin
                for (int k = 0; k < 8; k++) begin
                    if (r_addr[2:0] == 3'(k)) begin
                        w_frame_nx[39-5*k -: 5] = w_map[4:0];
                    end
                end
            end
            w_err_nx  = w_map[5];
            w_fv_nx   = (r_addr == 7'd7);
            w_addr_nx = r_inc ? r_addr + 7'd1 : r_addr - 7'd1;
        end
    end

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= PH_HIGH;
            r_four_bit <= 1'b0;
            r_hi_nib   <= '0;
            r_hi_dc    <= 1'b0;
            r_to_cnt   <= '0;
            r_addr     <= '0;
            r_inc      <= 1'b1;
            r_disp     <= 1'b0;
            r_frame    <= '1;
            r_fv       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_phase    <= w_phase_nx;
            r_four_bit <= w_four_bit_nx;
            r_hi_nib   <= w_hi_nib_nx;
            r_hi_dc    <= w_hi_dc_nx;
            r_to_cnt   <= w_to_cnt_nx;
            r_addr     <= w_addr_nx;
            r_inc      <= w_inc_nx;
            r_disp     <= w_disp_nx;
            r_frame    <= w_frame_nx;
            r_fv       <= w_fv_nx;
            r_err      <= w_err_nx;
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_fv;
    assign display_on  = r_disp;
    assign four_bit    = r_four_bit;
    assign err         = r_err;
    assign o_dbg_phase = (r_phase == PH_LOW);

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb_lcd_rx_monitor: directed bus transactions against a transaction-level
// display model; outputs compared every cycle plus literal pin checks.
module tb_lcd_rx_monitor;

    localparam int MIN_E  = 4;
    localparam int NIB_TO = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lcd_data = 4'h0;
    logic [2:0]  lcd_ctrl = 3'b000;
    logic [39:0] frame;
    logic        frame_valid, display_on, four_bit, err, dbg_phase;

    lcd_rx_monitor #(.MIN_E_HIGH(MIN_E), .NIB_TIMEOUT(NIB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .frame(frame), .frame_valid(frame_valid), .display_on(display_on),
        .four_bit(four_bit), .err(err), .o_dbg_phase(dbg_phase)
    );

    // clock
    always #5 clk = ~clk;

    // model state
    logic [4:0]  m_slot [8];
    logic [6:0]  m_addr;
    logic        m_inc, m_disp, m_four, m_pend, m_hi_dc;
    logic [3:0]  m_hi;
    int          m_age;
    logic        exp_fv, exp_err;
    logic [39:0] exp_q [$];
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          fv_seen = 0;
    int          err_seen = 0;
    string       code_tbl = "0123456789ABCDEF.:+-*/()<>mS";

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] model_frame();
        logic [39:0] f;
        for (int k = 0; k < 8; k++) f[39-5*k -: 5] = m_slot[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_slot[k] = 5'd31;
        m_addr = 7'd0; m_inc = 1'b1; m_disp = 1'b0; m_four = 1'b0;
        m_pend = 1'b0; m_hi = 4'h0; m_hi_dc = 1'b0; m_age = 0;
        exp_fv = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_data(input logic [7:0] b);
        logic [4:0] code;
        logic       bad;
        code = 5'd31;
        bad  = 1'b1;
        for (int i = 0; i < code_tbl.len(); i++)
            if (code_tbl[i] == b) begin code = 5'(i); bad = 1'b0; end
        if (b == 8'hE4) begin code = 5'd28; bad = 1'b0; end
        if (b == 8'hF4) begin code = 5'd29; bad = 1'b0; end
        if (b == 8'h3D) begin code = 5'd30; bad = 1'b0; end
        if (b == 8'hFE || b == 8'h20) begin code = 5'd31; bad = 1'b0; end
        if (m_addr < 7'd8) m_slot[m_addr[2:0]] = code;
        if (bad) exp_err = 1'b1;
        if (m_addr == 7'd7) begin
            exp_fv = 1'b1;
            exp_q.push_back(model_frame());
        end
        m_addr = m_inc ? m_addr + 7'd1 : m_addr - 7'd1;
    endtask

    task automatic model_cmd(input logic [7:0] b);
        if (b[7]) m_addr = b[6:0];
        else if (b[6]) ;
        else if (b[5]) begin
            if (b[4]) m_four = 1'b0;
            else if (!m_four) m_four = 1'b1;
        end
        else if (b[4]) ;
        else if (b[3]) m_disp = b[2];
        else if (b[2]) m_inc = b[1];
        else if (b[1]) m_addr = 7'd0;
        else if (b[0]) begin
            for (int k = 0; k < 8; k++) m_slot[k] = 5'd31;
            m_addr = 7'd0; m_inc = 1'b1;
        end
    endtask

    task automatic model_strobe(input logic [3:0] nib, input logic dc, input logic rw, input int hi_len);
        if (hi_len < MIN_E || rw) return;
        if (!m_four) begin
            if (!dc) model_cmd({nib, 4'h0});
        end else if (!m_pend) begin
            m_pend = 1'b1; m_hi = nib; m_hi_dc = dc; m_age = 0;
        end else begin
            m_pend = 1'b0;
            if (m_hi_dc) model_data({m_hi, nib});
            else model_cmd({m_hi, nib});
        end
    endtask

    // one clock: pulses last one cycle, reset and nibble timeout apply at the edge
    task automatic tick();
        @(posedge clk);
        #1;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (!rst_n) model_reset();
        else if (m_pend) begin
            m_age++;
            if (m_age == NIB_TO) begin m_pend = 1'b0; exp_err = 1'b1; end
        end
    endtask

    // driver: data settles 2 cycles, E high hi_len cycles, then recovery gap
    task automatic strobe(input logic [3:0] nib, input logic dc, input logic rw, input int hi_len);
        lcd_data = nib;
        lcd_ctrl = {1'b0, dc, rw};
        tick(); tick();
        lcd_ctrl[2] = 1'b1;
        repeat (hi_len) tick();
        lcd_ctrl[2] = 1'b0;
        tick(); tick(); tick();
        model_strobe(nib, dc, rw, hi_len);
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        strobe(b[7:4], dc, 1'b0, 12);
        strobe(b[3:0], dc, 1'b0, 12);
    endtask

    // scoreboard: every cycle against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("frame", frame, model_frame());
            check("frame_valid", 40'(frame_valid), 40'(exp_fv));
            check("err", 40'(err), 40'(exp_err));
            check("display_on", 40'(display_on), 40'(m_disp));
            check("four_bit", 40'(four_bit), 40'(m_four));
            check("phase", 40'(dbg_phase), 40'(m_pend));
            if (frame_valid) begin
                fv_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fv_frame: got unexpected pulse, required none at %0t", $time);
                end else begin
                    check("fv_frame", frame, exp_q.pop_front());
                end
            end
            if (err) err_seen++;
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] txt [8] = '{8'h31, 8'h32, 8'h2E, 8'h35, 8'h6D, 8'h53, 8'h3D, 8'h3E};

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();
        check("rst_frame", frame, {40{1'b1}});
        check("rst_four_bit", 40'(four_bit), 40'd0);
        check("rst_display_on", 40'(display_on), 40'd0);

        // power-on handshake, with a stray data strobe in 8-bit mode
        strobe(4'h3, 1'b1, 1'b0, 12);
        strobe(4'h3, 1'b0, 1'b0, 12);
        strobe(4'h3, 1'b0, 1'b0, 12);
        strobe(4'h3, 1'b0, 1'b0, 12);
        strobe(4'h2, 1'b0, 1'b0, 12);
        check("init_four_bit", 40'(four_bit), 40'd1);
        send_byte(8'h28, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h0C, 1'b0);
        send_byte(8'h01, 1'b0);
        check("init_frame", frame, {40{1'b1}});
        check("init_display_on", 40'(display_on), 40'd1);
        check("init_err_count", 40'(err_seen), 40'd0);

        // text "12.5mS=>"
        send_byte(8'h80, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(txt[i], 1'b1);
        check("text_frame", frame, 40'h08A05D6FD9);
        check("text_fv_count", 40'(fv_seen), 40'd1);

        // nibble timeout, then address 3 and write '0'
        strobe(4'h8, 1'b0, 1'b0, 12);
        repeat (NIB_TO + 5) tick();
        check("timeout_err_count", 40'(err_seen), 40'd1);
        check("timeout_phase", 40'(dbg_phase), 40'd0);
        send_byte(8'h83, 1'b0);
        send_byte(8'h30, 1'b1);
        check("slot3_zero", 40'(frame[24:20]), 40'd0);

        // short and read strobes are ignored in both phases
        strobe(4'h5, 1'b0, 1'b0, 2);
        strobe(4'h5, 1'b0, 1'b1, 12);
        check("glitch_phase_high", 40'(dbg_phase), 40'd0);
        strobe(4'h4, 1'b1, 1'b0, 12);
        check("hi_nibble_phase_low", 40'(dbg_phase), 40'd1);
        strobe(4'h9, 1'b1, 1'b0, 2);
        strobe(4'h9, 1'b1, 1'b1, 12);
        check("glitch_phase_low", 40'(dbg_phase), 40'd1);
        strobe(4'h7, 1'b1, 1'b0, 12);
        check("unmapped_slot4", 40'(frame[19:15]), 40'd31);
        check("unmapped_err_count", 40'(err_seen), 40'd2);

        // display off
        send_byte(8'h08, 1'b0);
        check("display_off", 40'(display_on), 40'd0);

        // address 0x7F: 'A' dropped, wrap, 'B' to slot 0, 'C' to slot 1
        send_byte(8'hFF, 1'b0);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        check("wrap_slot0", 40'(frame[39:35]), 40'd11);
        send_byte(8'h43, 1'b1);
        check("wrap_slot1", 40'(frame[34:30]), 40'd12);

        // decrement mode, write at 7 and downward wrap from 0
        send_byte(8'h04, 1'b0);
        send_byte(8'h87, 1'b0);
        send_byte(8'h44, 1'b1);
        check("dec_slot7", 40'(frame[4:0]), 40'd13);
        check("dec_fv_count", 40'(fv_seen), 40'd2);
        send_byte(8'h80, 1'b0);
        send_byte(8'h45, 1'b1);
        send_byte(8'h46, 1'b1);
        check("dec_wrap_slot0", 40'(frame[39:35]), 40'd14);

        // DL=1 drops back to 8-bit, then 4-bit again
        send_byte(8'h30, 1'b0);
        check("dl1_four_bit", 40'(four_bit), 40'd0);
        strobe(4'h2, 1'b0, 1'b0, 12);
        check("reinit_four_bit", 40'(four_bit), 40'd1);

        // reset between nibbles of 0x01
        strobe(4'h0, 1'b0, 1'b0, 12);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_frame", frame, {40{1'b1}});
        check("midrst_four_bit", 40'(four_bit), 40'd0);
        check("midrst_phase", 40'(dbg_phase), 40'd0);
        strobe(4'h1, 1'b0, 1'b0, 12);
        check("post_rst_four_bit", 40'(four_bit), 40'd0);
        check("post_rst_frame", frame, {40{1'b1}});

        repeat (3) tick();
        check("exp_q_empty", 40'(exp_q.size()), 40'd0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
